// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the ID/EX register slice and the ALU.
// The slave modport is the stage's view; the master modport is the surrounding pipeline.
interface id_ex_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_b5;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  pc;
  logic [4:0]       rd;
  logic             mem_we;
  logic [4:0]       mem_rd;
  logic [XLEN-1:0]  mem_data;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       alu_op;
  logic             funct7;
  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  logic [4:0]       rd_out;
  logic             reg_we;
  logic             is_load;
  logic             is_store;
  logic [XLEN-1:0]  store_data;
  logic             illegal;
  logic [CNT_W-1:0] xfer_count;

  modport slave (
    input  in_valid, opcode, funct3, funct7_b5, rs1_addr, rs2_addr, rs1_data, rs2_data,
           imm, pc, rd, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, alu_op, funct7, operand_a, operand_b, rd_out, reg_we,
           is_load, is_store, store_data, illegal, xfer_count
  );

  modport master (
    output in_valid, opcode, funct3, funct7_b5, rs1_addr, rs2_addr, rs1_data, rs2_data,
           imm, pc, rd, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, alu_op, funct7, operand_a, operand_b, rd_out, reg_we,
           is_load, is_store, store_data, illegal, xfer_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX register slice: operand forwarding, ALU control decode and a valid/ready
// output register with flush, plus a wrapping count of output handshakes.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [2:0]      alu_op;
    logic            funct7;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      rd;
    logic            reg_we;
    logic            is_load;
    logic            is_store;
    logic [XLEN-1:0] store_data;
    logic            illegal;
  } payload_t;

  logic             valid_q, valid_d;
  payload_t         pay_q, pay_d, dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [XLEN-1:0]  fwd_a, fwd_b;

  // MEM wins over WB; x0 always reads the register file value.
  function automatic logic [XLEN-1:0] forward(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            m_we,
    input logic [4:0]      m_rd,
    input logic [XLEN-1:0] m_data,
    input logic            w_we,
    input logic [4:0]      w_rd,
    input logic [XLEN-1:0] w_data
  );
    logic [XLEN-1:0] r;
    r = rf_data;
    if (addr != 5'd0 && m_we && m_rd == addr) begin
      r = m_data;
    end else if (addr != 5'd0 && w_we && w_rd == addr) begin
      r = w_data;
    end
    return r;
  endfunction

  assign fwd_a = forward(bus.rs1_addr, bus.rs1_data, bus.mem_we, bus.mem_rd, bus.mem_data,
                         bus.wb_we, bus.wb_rd, bus.wb_data);
  assign fwd_b = forward(bus.rs2_addr, bus.rs2_data, bus.mem_we, bus.mem_rd, bus.mem_data,
                         bus.wb_we, bus.wb_rd, bus.wb_data);

  assign bus.in_ready = bus.flush | ~valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

  always_comb begin
    dec    = '0;
    dec.rd = bus.rd;
    case (bus.opcode)
      OP_R: begin
        dec.alu_op    = bus.funct3;
        dec.funct7    = bus.funct7_b5;
        dec.operand_a = fwd_a;
        dec.operand_b = fwd_b;
        dec.reg_we    = 1'b1;
      end
      OP_IMM: begin
        // Only the shift-right immediates use bit 30; ADDI must never subtract.
        dec.alu_op    = bus.funct3;
        dec.funct7    = (bus.funct3 == 3'b101) & bus.funct7_b5;
        dec.operand_a = fwd_a;
        dec.operand_b = bus.imm;
        dec.reg_we    = 1'b1;
      end
      OP_LUI: begin
        dec.operand_b = bus.imm;
        dec.reg_we    = 1'b1;
      end
      OP_AUIPC: begin
        dec.operand_a = bus.pc;
        dec.operand_b = bus.imm;
        dec.reg_we    = 1'b1;
      end
      OP_LOAD: begin
        dec.operand_a = fwd_a;
        dec.operand_b = bus.imm;
        dec.reg_we    = 1'b1;
        dec.is_load   = 1'b1;
      end
      OP_STORE: begin
        dec.operand_a  = fwd_a;
        dec.operand_b  = bus.imm;
        dec.is_store   = 1'b1;
        dec.store_data = fwd_b;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    if (bus.rd == 5'd0) begin
      dec.reg_we = 1'b0;
    end
  end

  // Flush beats accept, accept beats drain; the counter sees every handshake.
  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    cnt_d   = cnt_q;
    if (valid_q && bus.out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pay_d   = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.alu_op     = pay_q.alu_op;
  assign bus.funct7     = pay_q.funct7;
  assign bus.operand_a  = pay_q.operand_a;
  assign bus.operand_b  = pay_q.operand_b;
  assign bus.rd_out     = pay_q.rd;
  assign bus.reg_we     = pay_q.reg_we;
  assign bus.is_load    = pay_q.is_load;
  assign bus.is_store   = pay_q.is_store;
  assign bus.store_data = pay_q.store_data;
  assign bus.illegal    = pay_q.illegal;
  assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed decode table, multi-cycle corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        mem_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
  } in_t;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        funct7;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic [31:0] sd;
    logic        illegal;
  } pay_t;

  typedef struct {
    in_t  vin;
    pay_t vexp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  id_ex_stage_if #(.XLEN(32), .CNT_W(32)) bus ();
  id_ex_stage_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  id_ex_stage #(.XLEN(32), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  id_ex_stage #(.XLEN(32), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_in(input in_t v);
    bus.opcode    = v.opcode;
    bus.funct3    = v.funct3;
    bus.funct7_b5 = v.f7b5;
    bus.rs1_addr  = v.rs1_addr;
    bus.rs2_addr  = v.rs2_addr;
    bus.rs1_data  = v.rs1_data;
    bus.rs2_data  = v.rs2_data;
    bus.imm       = v.imm;
    bus.pc        = v.pc;
    bus.rd        = v.rd;
    bus.mem_we    = v.mem_we;
    bus.mem_rd    = v.mem_rd;
    bus.mem_data  = v.mem_data;
    bus.wb_we     = v.wb_we;
    bus.wb_rd     = v.wb_rd;
    bus.wb_data   = v.wb_data;
  endtask

  function automatic pay_t get_act();
    pay_t p;
    p.alu_op   = bus.alu_op;
    p.funct7   = bus.funct7;
    p.a        = bus.operand_a;
    p.b        = bus.operand_b;
    p.rd       = bus.rd_out;
    p.reg_we   = bus.reg_we;
    p.is_load  = bus.is_load;
    p.is_store = bus.is_store;
    p.sd       = bus.store_data;
    p.illegal  = bus.illegal;
    return p;
  endfunction

  function automatic logic [31:0] ref_src(input logic [4:0] addr, input logic [31:0] rf, input in_t v);
    if (addr == 5'd0) return rf;
    if (v.mem_we && v.mem_rd == addr) return v.mem_data;
    if (v.wb_we && v.wb_rd == addr) return v.wb_data;
    return rf;
  endfunction

  // What the ALU should see for one instruction, straight from the opcode table.
  function automatic pay_t exp_decode(input in_t v);
    pay_t p;
    logic [31:0] ra, rb;
    p    = '0;
    ra   = ref_src(v.rs1_addr, v.rs1_data, v);
    rb   = ref_src(v.rs2_addr, v.rs2_data, v);
    p.rd = v.rd;
    if (v.opcode == 7'h33) begin
      p.alu_op = v.funct3; p.funct7 = v.f7b5; p.a = ra; p.b = rb; p.reg_we = 1'b1;
    end else if (v.opcode == 7'h13) begin
      p.alu_op = v.funct3; p.funct7 = (v.funct3 == 3'd5) ? v.f7b5 : 1'b0;
      p.a = ra; p.b = v.imm; p.reg_we = 1'b1;
    end else if (v.opcode == 7'h37) begin
      p.b = v.imm; p.reg_we = 1'b1;
    end else if (v.opcode == 7'h17) begin
      p.a = v.pc; p.b = v.imm; p.reg_we = 1'b1;
    end else if (v.opcode == 7'h03) begin
      p.a = ra; p.b = v.imm; p.reg_we = 1'b1; p.is_load = 1'b1;
    end else if (v.opcode == 7'h23) begin
      p.a = ra; p.b = v.imm; p.is_store = 1'b1; p.sd = rb;
    end else begin
      p.illegal = 1'b1;
    end
    if (v.rd == 5'd0) p.reg_we = 1'b0;
    return p;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    logic [6:0] ops [8];
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h37; ops[3] = 7'h17;
    ops[4] = 7'h03; ops[5] = 7'h23; ops[6] = 7'h73; ops[7] = 7'($urandom);
    v.opcode   = ops[$urandom_range(0, 7)];
    v.funct3   = 3'($urandom);
    v.f7b5     = 1'($urandom);
    v.rs1_addr = 5'($urandom_range(0, 3));
    v.rs2_addr = 5'($urandom_range(0, 3));
    v.rs1_data = $urandom;
    v.rs2_data = $urandom;
    v.imm      = $urandom;
    v.pc       = $urandom;
    v.rd       = 5'($urandom_range(0, 3));
    v.mem_we   = 1'($urandom);
    v.mem_rd   = 5'($urandom_range(0, 3));
    v.mem_data = $urandom;
    v.wb_we    = 1'($urandom);
    v.wb_rd    = 5'($urandom_range(0, 3));
    v.wb_data  = $urandom;
    return v;
  endfunction

  function automatic in_t mk_lui(input logic [31:0] imm);
    in_t v;
    v        = '0;
    v.opcode = 7'h37;
    v.imm    = imm;
    v.rd     = 5'd1;
    return v;
  endfunction

  function automatic pay_t lui_exp(input logic [31:0] imm);
    pay_t p;
    p        = '0;
    p.b      = imm;
    p.rd     = 5'd1;
    p.reg_we = 1'b1;
    return p;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  vec_t tbl[$];
  pay_t q[$];

  task automatic add(input in_t i, input pay_t e);
    vec_t r;
    r.vin  = i;
    r.vexp = e;
    tbl.push_back(r);
  endtask

  initial begin
    in_t         v;
    int unsigned exp_cnt;
    logic        iv, fl, ordy, exp_rdy;

    add('{7'h13,3'd0,1'b1,5'd1,5'd31,32'd10,32'd7,32'hFFFFFFFF,32'h100,5'd5,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
        '{3'd0,1'b0,32'd10,32'hFFFFFFFF,5'd5,1'b1,1'b0,1'b0,32'd0,1'b0});
    add('{7'h33,3'd0,1'b1,5'd3,5'd0,32'h11,32'h22,32'h0,32'h104,5'd7,1'b1,5'd3,32'h55,1'b1,5'd3,32'h66},
        '{3'd0,1'b1,32'h55,32'h22,5'd7,1'b1,1'b0,1'b0,32'd0,1'b0});
    add('{7'h33,3'd0,1'b0,5'd0,5'd0,32'hA,32'hB,32'h0,32'h108,5'd2,1'b1,5'd0,32'h55,1'b1,5'd0,32'h66},
        '{3'd0,1'b0,32'hA,32'hB,5'd2,1'b1,1'b0,1'b0,32'd0,1'b0});
    add('{7'h37,3'd3,1'b0,5'd1,5'd0,32'h99,32'h0,32'h12345000,32'h10C,5'd4,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
        '{3'd0,1'b0,32'd0,32'h12345000,5'd4,1'b1,1'b0,1'b0,32'd0,1'b0});
    add('{7'h73,3'd2,1'b0,5'd1,5'd2,32'd5,32'd6,32'd7,32'h110,5'd9,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
        '{3'd0,1'b0,32'd0,32'd0,5'd9,1'b0,1'b0,1'b0,32'd0,1'b1});
    add('{7'h17,3'd0,1'b0,5'd0,5'd0,32'd0,32'd0,32'h1000,32'h80000040,5'd10,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
        '{3'd0,1'b0,32'h80000040,32'h1000,5'd10,1'b1,1'b0,1'b0,32'd0,1'b0});
    add('{7'h13,3'd5,1'b1,5'd2,5'd3,32'hF0,32'h0,32'h403,32'h118,5'd11,1'b0,5'd2,32'h55,1'b1,5'd2,32'h77},
        '{3'd5,1'b1,32'h77,32'h403,5'd11,1'b1,1'b0,1'b0,32'd0,1'b0});
    add('{7'h03,3'd2,1'b0,5'd4,5'd0,32'h1000,32'h0,32'd8,32'h11C,5'd0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
        '{3'd0,1'b0,32'h1000,32'd8,5'd0,1'b0,1'b1,1'b0,32'd0,1'b0});
    add('{7'h23,3'd2,1'b0,5'd5,5'd6,32'h2000,32'hDEAD,32'h10,32'h120,5'd8,1'b1,5'd6,32'hBEEF,1'b1,5'd5,32'h3000},
        '{3'd0,1'b0,32'h3000,32'h10,5'd8,1'b0,1'b0,1'b1,32'hBEEF,1'b0});
    add('{7'h33,3'd2,1'b0,5'd7,5'd7,32'd1,32'd2,32'h0,32'h124,5'd12,1'b0,5'd7,32'h55,1'b1,5'd7,32'h42},
        '{3'd2,1'b0,32'h42,32'h42,5'd12,1'b1,1'b0,1'b0,32'd0,1'b0});

    apply_in('0);
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b1;  bus2.opcode = 7'h37; bus2.funct3 = 3'd0; bus2.funct7_b5 = 1'b0;
    bus2.rs1_addr = 5'd0;  bus2.rs2_addr = 5'd0; bus2.rs1_data = 32'd0; bus2.rs2_data = 32'd0;
    bus2.imm = 32'h1;      bus2.pc = 32'd0; bus2.rd = 5'd1;
    bus2.mem_we = 1'b0;    bus2.mem_rd = 5'd0; bus2.mem_data = 32'd0;
    bus2.wb_we = 1'b0;     bus2.wb_rd = 5'd0; bus2.wb_data = 32'd0;
    bus2.flush = 1'b0;     bus2.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
    chk("reset_count", 128'(bus.xfer_count), 128'(32'd0));
    chk("reset_payload", 128'(get_act()), 128'(pay_t'('0)));
    rst = 1'b0;

    // Decode/forwarding table, streamed back-to-back with out_ready high.
    foreach (tbl[i]) begin
      apply_in(tbl[i].vin);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("tbl%0d_valid", i), 128'(bus.out_valid), 128'(1'b1));
      chk($sformatf("tbl%0d_payload", i), 128'(get_act()), 128'(tbl[i].vexp));
    end
    tick();
    chk("tbl_count", 128'(bus.xfer_count), 128'(32'(tbl.size())));

    // Reset while a payload is held under backpressure.
    apply_in(tbl[6].vin);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("hold_valid", 128'(bus.out_valid), 128'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("rst_mid_opa", 128'(bus.operand_a), 128'(32'd0));
    chk("rst_mid_count", 128'(bus.xfer_count), 128'(32'd0));
    tick();
    rst = 1'b0;

    // Backpressure: three instructions, out_ready low for two cycles after the first.
    apply_in(mk_lui(32'd1)); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    apply_in(mk_lui(32'd2)); bus.out_ready = 1'b0;
    #1;
    chk("bp_stall1_in_ready", 128'(bus.in_ready), 128'(1'b0));
    chk("bp_stall1_payload", 128'(get_act()), 128'(lui_exp(32'd1)));
    tick();
    chk("bp_stall2_in_ready", 128'(bus.in_ready), 128'(1'b0));
    chk("bp_stall2_payload", 128'(get_act()), 128'(lui_exp(32'd1)));
    chk("bp_stall2_valid", 128'(bus.out_valid), 128'(1'b1));
    tick();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 128'(bus.in_ready), 128'(1'b1));
    chk("bp_first", 128'(get_act()), 128'(lui_exp(32'd1)));
    tick();
    apply_in(mk_lui(32'd3));
    chk("bp_second", 128'(get_act()), 128'(lui_exp(32'd2)));
    tick();
    bus.in_valid = 1'b0;
    chk("bp_third", 128'(get_act()), 128'(lui_exp(32'd3)));
    chk("bp_third_valid", 128'(bus.out_valid), 128'(1'b1));
    tick();
    chk("bp_drained", 128'(bus.out_valid), 128'(1'b0));
    chk("bp_count", 128'(bus.xfer_count), 128'(32'd3));

    // Flush over a held instruction with a new one arriving.
    apply_in(mk_lui(32'd4)); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    apply_in(mk_lui(32'd5)); bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", 128'(bus.in_ready), 128'(1'b1));
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("flush_count", 128'(bus.xfer_count), 128'(32'd3));

    // Counter wrap on the narrow instance: streaming from reset, handshakes start on the 2nd edge.
    do_reset();
    repeat (4) tick();
    chk("wrap_at_max", 128'(bus2.xfer_count), 128'(2'd3));
    tick();
    chk("wrap_to_zero", 128'(bus2.xfer_count), 128'(2'd0));

    // Random traffic against a one-deep queue model.
    do_reset();
    q.delete();
    exp_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      v    = rand_in();
      iv   = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 9) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      apply_in(v);
      bus.in_valid  = iv;
      bus.flush     = fl;
      bus.out_ready = ordy;
      #1;
      exp_rdy = fl | (q.size() == 0) | ordy;
      chk("rnd_in_ready", 128'(bus.in_ready), 128'(exp_rdy));
      chk("rnd_out_valid", 128'(bus.out_valid), 128'(q.size() != 0));
      if (q.size() != 0) chk("rnd_payload", 128'(get_act()), 128'(q[0]));
      chk("rnd_count", 128'(bus.xfer_count), 128'(exp_cnt));
      if (q.size() != 0 && ordy) begin
        void'(q.pop_front());
        exp_cnt++;
      end
      if (fl) q.delete();
      else if (iv && exp_rdy) q.push_back(exp_decode(v));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
